// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead add/sub: one BLOCK-bit lookahead group per stage, group carry registered between stages.
// Latency NSTAGE = WIDTH/BLOCK cycles from the input transfer edge; one operation per cycle when not stalled.
// Backpressure: stall = out_valid & ~out_ready freezes every stage and drops in_ready. Optional macro CLA_OVF_EN adds ovf.
module pipelined_cla_adder #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    // WIDTH must be a multiple of BLOCK; the stage count truncates otherwise.
    localparam int NSTAGE = WIDTH / BLOCK;

    // One lookahead group: {carry_out, sum}. Every internal carry is written as
    // a flat sum-of-products of G/P terms and the group carry-in (no rippling).
    function automatic logic [BLOCK:0] cla_group(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int m = 0; m <= i; m++) term = term & p[m];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    logic             stall;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;

    // Subtraction folds into the adder: invert B and force the carry-in.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign b_eff    = sub ? ~B : B;
    assign cin0     = sub | C_in;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        // Operand bits still to be consumed when entering stage k (groups k..NSTAGE-1).
        localparam int OW = WIDTH - k * BLOCK;

        logic [OW-1:0]          a_src;
        logic [OW-1:0]          b_src;
        logic                   c_src;
        logic                   v_src;
        logic [BLOCK:0]         grp;
        logic [(k+1)*BLOCK-1:0] s_nxt;
        logic [(k+1)*BLOCK-1:0] s_q;
        logic                   c_q;
        logic                   v_q;

        if (k == 0) begin : g_head
            assign a_src = A;
            assign b_src = b_eff;
            assign c_src = cin0;
            assign v_src = in_valid;
            assign s_nxt = grp[BLOCK-1:0];
        end else begin : g_tail
            assign a_src = g_stage[k-1].g_ops.a_q;
            assign b_src = g_stage[k-1].g_ops.b_q;
            assign c_src = g_stage[k-1].c_q;
            assign v_src = g_stage[k-1].v_q;
            assign s_nxt = {grp[BLOCK-1:0], g_stage[k-1].s_q};
        end

        // The lowest pending group is always the one this stage resolves.
        assign grp = cla_group(a_src[BLOCK-1:0], b_src[BLOCK-1:0], c_src);

        // Result bits accumulated so far, group carry and slot valid; hold on stall.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (!stall) begin
                s_q <= s_nxt;
                c_q <= grp[BLOCK];
                v_q <= v_src;
            end
        end

        if (k < NSTAGE - 1) begin : g_ops
            logic [OW-BLOCK-1:0] a_q;
            logic [OW-BLOCK-1:0] b_q;

            // Skew: upper operand groups wait here until their carry arrives.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (!stall) begin
                    a_q <= a_src[OW-1:BLOCK];
                    b_q <= b_src[OW-1:BLOCK];
                end
            end
        end
    end

    assign S         = g_stage[NSTAGE-1].s_q;
    assign C_out     = g_stage[NSTAGE-1].c_q;
    assign out_valid = g_stage[NSTAGE-1].v_q;

`ifdef CLA_OVF_EN
    logic ovf_nxt;
    logic ovf_q;

    // Carry into the MSB is recovered as P ^ S at that bit (sum = P ^ carry).
    assign ovf_nxt = g_stage[NSTAGE-1].a_src[BLOCK-1] ^ g_stage[NSTAGE-1].b_src[BLOCK-1]
                   ^ g_stage[NSTAGE-1].grp[BLOCK-1] ^ g_stage[NSTAGE-1].grp[BLOCK];

    // Overflow flag registered alongside the last result group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (!stall) begin
            ovf_q <= ovf_nxt;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule
